// File: rtl/letter_reveal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : letter_reveal_ctrl
// Brief    : Scans a size_y x size_x letter grid for a guessed letter and
//            accumulates a reveal mask; also clears the mask row by row.
// Revision : 1.0 - initial release
// ============================================================================
module letter_reveal_ctrl #(
    parameter int size_y = 20,
    parameter int size_x = 40
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              guess_valid,
    input  logic [7:0]                        guess_letter,
    output logic                              guess_ready,
    input  logic                              clear_req,
    output logic [4:0]                        cell_y,
    output logic [5:0]                        cell_x,
    input  logic [7:0]                        cell_letter,
    output logic [0:size_x-1][size_y-1:0]     maze_letters,
    output logic                              busy,
    output logic                              done,
    output logic [9:0]                        match_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0] c_YMAX = 5'(size_y - 1);
    localparam logic [5:0] c_XMAX = 6'(size_x - 1);

    logic [1:0]                    state_q,  state_d;
    logic [7:0]                    letter_q, letter_d;
    logic [4:0]                    y_q,      y_d;
    logic [5:0]                    x_q,      x_d;
    logic                          pend_q,   pend_d;
    logic [9:0]                    count_q,  count_d;
    logic [0:size_x-1][size_y-1:0] mask_q,   mask_d;

    logic w_accept;
    logic w_hit;
    logic w_new;

    assign guess_ready = (state_q == S_IDLE) && !clear_req && !pend_q;
    assign w_accept    = guess_valid && guess_ready;

    // A null letter never matches, so blank (8'h00) cells stay hidden.
    assign w_hit = (state_q == S_SCAN) && (letter_q != 8'h00) &&
                   (cell_letter == letter_q);
    assign w_new = w_hit && !mask_q[x_q][y_q];

    always_comb begin
        state_d  = state_q;
        letter_d = letter_q;
        y_d      = y_q;
        x_d      = x_q;
        pend_d   = pend_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (clear_req || pend_q) begin
                    state_d = S_CLEAR;
                    pend_d  = 1'b0;
                    y_d     = 5'd0;
                    x_d     = 6'd0;
                    count_d = 10'd0;
                end else if (w_accept) begin
                    state_d  = S_SCAN;
                    letter_d = guess_letter;
                    y_d      = 5'd0;
                    x_d      = 6'd0;
                    count_d  = 10'd0;
                end
            end
            S_SCAN: begin
                pend_d = pend_q || clear_req;
                if (w_new) begin
                    count_d = count_q + 10'd1;
                end
                if (x_q == c_XMAX) begin
                    x_d = 6'd0;
                    if (y_q == c_YMAX) begin
                        y_d     = 5'd0;
                        state_d = S_DONE;
                    end else begin
                        y_d = y_q + 5'd1;
                    end
                end else begin
                    x_d = x_q + 6'd1;
                end
            end
            S_CLEAR: begin
                pend_d = pend_q || clear_req;
                if (y_q == c_YMAX) begin
                    y_d     = 5'd0;
                    state_d = S_DONE;
                end else begin
                    y_d = y_q + 5'd1;
                end
            end
            default: begin
                pend_d  = pend_q || clear_req;
                state_d = S_IDLE;
            end
        endcase
    end

    // In CLEAR the row counter y_q selects which row is wiped this cycle.
    always_comb begin
        mask_d = mask_q;
        if (state_q == S_CLEAR) begin
            for (int xi = 0; xi < size_x; xi++) begin
                mask_d[xi][y_q] = 1'b0;
            end
        end
        if (w_hit) begin
            mask_d[x_q][y_q] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            letter_q <= 8'h00;
            y_q      <= 5'd0;
            x_q      <= 6'd0;
            pend_q   <= 1'b0;
            count_q  <= 10'd0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            letter_q <= letter_d;
            y_q      <= y_d;
            x_q      <= x_d;
            pend_q   <= pend_d;
            count_q  <= count_d;
            mask_q   <= mask_d;
        end
    end

    assign cell_y       = (state_q == S_SCAN) ? y_q : 5'd0;
    assign cell_x       = (state_q == S_SCAN) ? x_q : 6'd0;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign match_count  = count_q;
    assign maze_letters = mask_q;

endmodule
`default_nettype wire
